// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive path.
package uart_pkg;

  // Default baud timing: 50 MHz system clock, 115200 baud.
  localparam int CLKS_PER_BIT_DEF = 434;
  // Default frame: 8 data bits, no parity, one stop bit.
  localparam int DATA_BITS_DEF    = 8;

  // Serial-side phase of the receive datapath.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,  // waiting for a high-to-low edge on the line
    START_CHK = 2'd1,  // timing to mid start bit to reject glitches
    DATA      = 2'd2   // sampling data bits, then the stop-bit slot
  } phase_e;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample their inputs at the same edge; blocking here would collapse the
  // chain into a single flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/uart_rx_datapath.sv
// Serial-side datapath of the UART receiver: synchronises the line,
// qualifies the start bit, times mid-bit sampling, assembles the byte
// under controller strobes and reports status pulses back.
module uart_rx_datapath
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_serial,
  input  logic                 bit_clr,
  input  logic                 take_value,
  input  logic                 incre_counter,
  input  logic                 get_output,
  output logic                 start_bit,
  output logic                 get_value,
  output logic                 data_received,
  output logic                 stop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(DATA_BITS + 1);

  // Last count of a full bit period and of half a bit period.
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BITS_ALL  = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0]  BITS_LAST = CNT_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_prev;
  phase_e               phase;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [CNT_W-1:0]     dp_bits;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 sample_bit;

  // NOTE: the synchroniser and rx_prev reset to 1 (idle line) so that
  // leaving reset never looks like a falling start edge.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_serial),
    .q     (rx_s)
  );

  // One-cycle delayed copy of the synchronised line for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= rx_s;
    end
  end

  // Phase FSM: start qualification, mid-bit sampling and stop-bit check,
  // with all status pulses registered and cleared by default each cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase      <= IDLE;
      baud_cnt   <= '0;
      dp_bits    <= '0;
      sample_bit <= 1'b0;
      start_bit  <= 1'b0;
      get_value  <= 1'b0;
      stop       <= 1'b0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      start_bit <= 1'b0;
      get_value <= 1'b0;
      stop      <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      case (phase)
        IDLE: begin
          // Only a genuine high-to-low transition starts a frame; a line
          // stuck low (break) stays here until it goes high again.
          if (rx_prev && !rx_s) begin
            phase    <= START_CHK;
            baud_cnt <= '0;
          end
        end

        START_CHK: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            if (!rx_s) begin
              start_bit <= 1'b1;
              phase     <= DATA;
              dp_bits   <= '0;
            end else begin
              // Line back high at mid start bit: a glitch, not a frame.
              phase <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DATA: begin
          // Falling edges are ignored here; timing is purely count based.
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (dp_bits != BITS_ALL) begin
              sample_bit <= rx_s;
              get_value  <= 1'b1;
              dp_bits    <= dp_bits + CNT_W'(1);
            end else begin
              // Stop-bit slot: report it and go straight back to IDLE so
              // a back-to-back start edge is caught immediately.
              stop      <= 1'b1;
              rx_valid  <= rx_s;
              frame_err <= !rx_s;
              phase     <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          phase <= IDLE;
        end
      endcase
    end
  end

  // Controller-driven bit counter, shift register and output byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
    end else begin
      // Clear wins over increment; the counter saturates at DATA_BITS.
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (incre_counter && (bit_cnt != BITS_ALL)) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      // LSB arrives first, so new bits enter at the top and move down.
      if (take_value) begin
        shift_reg <= {sample_bit, shift_reg[DATA_BITS-1:1]};
      end

      // shift_reg is stable while get_output is held, so reloading every
      // cycle is harmless and rx_data settles one cycle after it rises.
      if (get_output) begin
        rx_data <= shift_reg;
      end
    end
  end

  // High while the controller is taking the final data bit of the frame.
  assign data_received = (bit_cnt == BITS_LAST);

endmodule : uart_rx_datapath

// File: tb/tb_uart_rx_datapath.sv
// Self-checking bench for uart_rx_datapath. The bench plays both the UART
// transmitter on rx_serial and the receive controller on the strobe inputs.
module tb_uart_rx_datapath;

  localparam int CPB       = 8;
  localparam int DB        = 8;
  localparam int FRAME_LEN = CPB * (DB + 2);
  // Edge on the line -> 2 sync flops -> 1 edge detect -> half bit.
  localparam int START_AT  = 2 + 1 + CPB / 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_serial = 1'b1;
  logic          bit_clr = 1'b0;
  logic          take_value = 1'b0;
  logic          incre_counter = 1'b0;
  logic          get_output = 1'b0;
  logic          start_bit;
  logic          get_value;
  logic          data_received;
  logic          stop;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_datapath #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_serial     (rx_serial),
    .bit_clr       (bit_clr),
    .take_value    (take_value),
    .incre_counter (incre_counter),
    .get_output    (get_output),
    .start_bit     (start_bit),
    .get_value     (get_value),
    .data_received (data_received),
    .stop          (stop),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transmitted line level k cycles after the start edge of a frame.
  function automatic logic line_bit(input logic [DB-1:0] data,
                                    input logic stop_val, input int k);
    if (k < CPB) return 1'b0;
    if (k < CPB * (DB + 1)) return data[(k - CPB) / CPB];
    return stop_val;
  endfunction

  // Hold the line at a fixed level with the controller quiet, counting
  // any status pulses seen.
  task automatic hold_line(input logic level, input int n,
                           output int starts, output int gvs,
                           output int stops, output int errs);
    starts = 0; gvs = 0; stops = 0; errs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      starts += int'(start_bit);
      gvs    += int'(get_value);
      stops  += int'(stop);
      errs   += int'(frame_err) + int'(rx_valid);
      bit_clr = 1'b0; take_value = 1'b0; incre_counter = 1'b0;
      get_output = 1'b0;
      rx_serial = level;
    end
  endtask

  // Send one frame and act as the receive controller. abort_k >= 0 pulls
  // reset at that cycle of the frame instead of finishing it.
  task automatic send_frame(input logic [DB-1:0] data, input logic stop_val,
                            input int abort_k, input string name);
    int start_k = -1, start_cnt = 0, stop_k = -1, stop_cnt = 0;
    int gv_cnt = 0, first_gv = -1, last_gv = -1, takes = 0;
    int valid_cnt = 0, ferr_cnt = 0;
    bit spacing_ok = 1'b1, arm = 1'b0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      @(negedge clk);
      check({name, " one_pulse"},
            32'(($countones({start_bit, get_value, stop}) <= 1)), 32'd1);
      if (start_bit) begin
        if (start_k < 0) start_k = k;
        start_cnt++;
      end
      if (get_value) begin
        if (last_gv >= 0 && (k - last_gv) != CPB) spacing_ok = 1'b0;
        if (first_gv < 0) first_gv = k;
        last_gv = k;
        gv_cnt++;
      end
      if (stop) begin
        stop_k = k;
        stop_cnt++;
      end
      if (rx_valid) begin
        valid_cnt++;
        check({name, " rx_data_at_valid"}, 32'(rx_data), 32'(data));
      end
      if (frame_err) ferr_cnt++;

      // Controller responses for the next clock edge.
      bit_clr       = start_bit;
      take_value    = get_value;
      incre_counter = get_value;
      if (get_value) begin
        check({name, " data_received"}, 32'(data_received),
              32'(takes == DB - 1));
        takes++;
      end
      if (stop) get_output = 1'b0;
      else if (arm) get_output = 1'b1;
      arm = get_value && (takes == DB);

      if (k == abort_k) begin
        reset = 1'b0;
        rx_serial = 1'b1;
        bit_clr = 1'b0; take_value = 1'b0; incre_counter = 1'b0;
        get_output = 1'b0;
        #1;
        check({name, " outs_in_reset"},
              32'({start_bit, get_value, stop, rx_valid, frame_err,
                   data_received, rx_data}), 32'd0);
        repeat (3) @(negedge clk);
        check({name, " outs_held_reset"},
              32'({start_bit, get_value, stop, rx_valid, frame_err,
                   data_received, rx_data}), 32'd0);
        check({name, " aborted_valid"}, 32'(valid_cnt), 32'd0);
        reset = 1'b1;
        return;
      end
      rx_serial = line_bit(data, stop_val, k);
    end
    check({name, " start_time"}, 32'(start_k), 32'(START_AT));
    check({name, " start_cnt"}, 32'(start_cnt), 32'd1);
    check({name, " gv_cnt"}, 32'(gv_cnt), 32'(DB));
    check({name, " first_gv"}, 32'(first_gv), 32'(START_AT + CPB));
    check({name, " gv_spacing"}, 32'(spacing_ok), 32'd1);
    check({name, " stop_time"}, 32'(stop_k), 32'(START_AT + CPB * (DB + 1)));
    check({name, " stop_cnt"}, 32'(stop_cnt), 32'd1);
    check({name, " valid_cnt"}, 32'(valid_cnt), 32'(stop_val ? 1 : 0));
    check({name, " ferr_cnt"}, 32'(ferr_cnt), 32'(stop_val ? 0 : 1));
    check({name, " rx_data"}, 32'(rx_data), 32'(data));
  endtask

  initial begin
    int s, g, p, e;
    int s2, g2, p2, e2;
    logic [DB-1:0] rnd;

    // Reset state.
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pulses",
          32'({start_bit, get_value, stop, rx_valid, frame_err, data_received}),
          32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    reset = 1'b1;
    hold_line(1'b1, 5, s, g, p, e);
    check("idle_quiet", 32'(s + g + p + e), 32'd0);

    // Basic frame.
    send_frame(8'hA5, 1'b1, -1, "a5");
    hold_line(1'b1, 4, s, g, p, e);

    // Short low glitch on an idle line must be rejected.
    hold_line(1'b0, 3, s, g, p, e);
    hold_line(1'b1, 20, s2, g2, p2, e2);
    check("glitch_start", 32'(s + s2), 32'd0);
    check("glitch_gv", 32'(g + g2 + p + p2), 32'd0);

    // Bad stop bit, followed by a break (line held low).
    send_frame(8'h3C, 1'b0, -1, "3c_ferr");
    hold_line(1'b0, 30, s, g, p, e);
    check("break_quiet", 32'(s + g + p + e), 32'd0);
    hold_line(1'b1, 6, s, g, p, e);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, -1, "b2b_00");
    send_frame(8'hFF, 1'b1, -1, "b2b_ff");
    hold_line(1'b1, 4, s, g, p, e);

    // Reset during the 4th data bit, then a clean frame.
    send_frame(8'h81, 1'b1, CPB * 4 + 3, "abort_81");
    hold_line(1'b1, 4, s, g, p, e);
    check("post_abort_quiet", 32'(s + g + p + e), 32'd0);
    send_frame(8'h55, 1'b1, -1, "55");

    // Random bytes with random idle gaps (including none).
    for (int i = 0; i < 6; i++) begin
      rnd = DB'($urandom);
      send_frame(rnd, 1'b1, -1, $sformatf("rnd%0d", i));
      hold_line(1'b1, int'($urandom_range(0, 5)), s, g, p, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_datapath
